// File: rtl/vend_pkg.sv
// Shared encodings and helpers for the multi-product vending controller.
package vend_pkg;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;
  localparam logic [1:0] COIN_20   = 2'b11;

  localparam logic [1:0] CHG_NONE = 2'b00;
  localparam logic [1:0] CHG_5    = 2'b01;
  localparam logic [1:0] CHG_10   = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_VEND    = 2'd2,
    ST_REFUND  = 2'd3
  } vend_state_t;

  // Credit units carried by one coin (1 unit = Rs.5).
  function automatic logic [2:0] coin_units(input logic [1:0] coin);
    case (coin)
      COIN_5:  coin_units = 3'd1;
      COIN_10: coin_units = 3'd2;
      COIN_20: coin_units = 3'd4;
      default: coin_units = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/vend_change_gen.sv
// Picks the next refund coin (largest first) and the credit left after paying it.
module vend_change_gen
  import vend_pkg::*;
#(
  parameter int CREDIT_W = 4
) (
  input  logic [CREDIT_W-1:0] credit,
  output logic [1:0]          coin,
  output logic [CREDIT_W-1:0] credit_next
);

  always_comb begin
    coin        = CHG_NONE;
    credit_next = '0;
    if (credit >= CREDIT_W'(2)) begin
      coin        = CHG_10;
      credit_next = credit - CREDIT_W'(2);
    end else if (credit == CREDIT_W'(1)) begin
      coin        = CHG_5;
      credit_next = '0;
    end
  end

endmodule

// File: rtl/vend_multi_fsm.sv
// Multi-product vending controller: saturating coin credit, priced selection,
// one-cycle dispense pulse and serial largest-first change.
//   state      | meaning
//   ST_IDLE    | no credit held
//   ST_COLLECT | credit held, accepting coins / select / cancel
//   ST_VEND    | one-cycle dispense pulse on out
//   ST_REFUND  | paying credit back one coin per cycle
module vend_multi_fsm
  import vend_pkg::*;
#(
  parameter int                         NUM_PROD   = 4,
  parameter int                         PRICE_W    = 4,
  parameter logic [NUM_PROD*PRICE_W-1:0] PRICES    = 16'h6423,
  parameter int                         MAX_CREDIT = 12,
  parameter int                         SEL_W      = (NUM_PROD > 1) ? $clog2(NUM_PROD) : 1,
  parameter int                         CREDIT_W   = $clog2(MAX_CREDIT + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          in,
  input  logic                sel_valid,
  input  logic [SEL_W-1:0]    sel,
  input  logic                cancel,
  output logic                out,
  output logic [SEL_W-1:0]    out_sel,
  output logic [1:0]          change,
  output logic                coin_rej,
  output logic                busy,
  output logic [CREDIT_W-1:0] credit
);

  for (genvar i = 0; i < NUM_PROD; i++) begin : g_price_chk
    if (int'(PRICES[i*PRICE_W +: PRICE_W]) == 0 ||
        int'(PRICES[i*PRICE_W +: PRICE_W]) > MAX_CREDIT) begin : g_bad
      $error("vend_multi_fsm: price of product %0d must be in 1..MAX_CREDIT", i);
    end
  end

  vend_state_t         state;
  logic [PRICE_W-1:0]  price_sel;
  logic                sel_ok;
  logic                coin_seen;
  logic [CREDIT_W:0]   credit_wide;
  logic [CREDIT_W:0]   coin_sum;
  logic [CREDIT_W:0]   price_wide;
  logic                can_buy;
  logic [1:0]          gen_coin;
  logic [CREDIT_W-1:0] gen_credit;

  always_comb begin
    price_sel = '0;
    for (int i = 0; i < NUM_PROD; i++) begin
      if (int'(sel) == i) price_sel = PRICES[i*PRICE_W +: PRICE_W];
    end
  end

  assign sel_ok      = int'(sel) < NUM_PROD;
  assign coin_seen   = (in != COIN_NONE);
  assign credit_wide = {1'b0, credit};
  assign coin_sum    = credit_wide + (CREDIT_W+1)'(coin_units(in));
  assign price_wide  = (CREDIT_W+1)'(price_sel);
  assign can_buy     = sel_valid && sel_ok && (credit_wide >= price_wide);

  vend_change_gen #(.CREDIT_W(CREDIT_W)) u_change_gen (
    .credit      (credit),
    .coin        (gen_coin),
    .credit_next (gen_credit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      credit   <= '0;
      out      <= 1'b0;
      out_sel  <= '0;
      change   <= CHG_NONE;
      coin_rej <= 1'b0;
      busy     <= 1'b0;
    end else begin
      out      <= 1'b0;
      change   <= CHG_NONE;
      coin_rej <= 1'b0;
      case (state)
        ST_IDLE, ST_COLLECT: begin
          // Only an effective cancel/select outranks the coin; ignored requests let it through.
          if (cancel && credit != '0) begin
            state    <= ST_REFUND;
            busy     <= 1'b1;
            coin_rej <= coin_seen;
          end else if (can_buy) begin
            credit   <= CREDIT_W'(credit_wide - price_wide);
            out      <= 1'b1;
            out_sel  <= sel;
            state    <= ST_VEND;
            busy     <= 1'b1;
            coin_rej <= coin_seen;
          end else if (coin_seen) begin
            if (coin_sum <= (CREDIT_W+1)'(MAX_CREDIT)) begin
              credit <= CREDIT_W'(coin_sum);
              state  <= ST_COLLECT;
            end else begin
              coin_rej <= 1'b1;
            end
          end
        end
        ST_VEND: begin
          coin_rej <= coin_seen;
          if (credit != '0) begin
            state <= ST_REFUND;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        ST_REFUND: begin
          coin_rej <= coin_seen;
          change   <= gen_coin;
          credit   <= gen_credit;
          if (gen_credit == '0) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vend_multi_fsm.sv
// Scoreboard bench: driver predicts each cycle's registered outputs from a
// transaction-level model; a monitor pops and compares after every clock edge.
module tb_vend_multi_fsm;
  import vend_pkg::*;

  localparam int SEL_W    = 2;
  localparam int CREDIT_W = 4;
  localparam int MAXC     = 12;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [1:0]          coin = 2'b00;
  logic                sel_valid = 1'b0;
  logic [SEL_W-1:0]    sel = '0;
  logic                cancel = 1'b0;
  logic                out;
  logic [SEL_W-1:0]    out_sel;
  logic [1:0]          change;
  logic                coin_rej;
  logic                busy;
  logic [CREDIT_W-1:0] credit;

  vend_multi_fsm dut (
    .clk       (clk),
    .rst       (rst),
    .in        (coin),
    .sel_valid (sel_valid),
    .sel       (sel),
    .cancel    (cancel),
    .out       (out),
    .out_sel   (out_sel),
    .change    (change),
    .coin_rej  (coin_rej),
    .busy      (busy),
    .credit    (credit)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: credit in units plus "dispensing" / "refunding" flags.
  int price_tab[4] = '{3, 2, 4, 6};
  int m_credit = 0;
  bit m_vend = 0;
  bit m_refund = 0;
  int m_sel = 0;
  logic [10:0] exp_q[$];

  function automatic int units(input logic [1:0] c);
    return (c == 2'b01) ? 1 : (c == 2'b10) ? 2 : (c == 2'b11) ? 4 : 0;
  endfunction

  task automatic model_and_push(input logic [1:0] c, input logic sv,
                                input logic [1:0] s, input logic cn);
    logic       e_out;
    logic [1:0] e_chg;
    logic       e_rej;
    int         pay;
    e_out = 0; e_chg = 2'b00; e_rej = 0;
    if (m_vend) begin
      m_vend   = 0;
      m_refund = (m_credit > 0);
      e_rej    = (c != 2'b00);
    end else if (m_refund) begin
      pay      = (m_credit >= 2) ? 2 : 1;
      m_credit = m_credit - pay;
      e_chg    = (pay == 2) ? 2'b10 : 2'b01;
      if (m_credit == 0) m_refund = 0;
      e_rej    = (c != 2'b00);
    end else if (cn && m_credit > 0) begin
      m_refund = 1;
      e_rej    = (c != 2'b00);
    end else if (sv && int'(s) < 4 && m_credit >= price_tab[s]) begin
      m_credit = m_credit - price_tab[s];
      m_sel    = int'(s);
      e_out    = 1;
      m_vend   = 1;
      e_rej    = (c != 2'b00);
    end else if (c != 2'b00) begin
      if (m_credit + units(c) <= MAXC) m_credit = m_credit + units(c);
      else e_rej = 1;
    end
    exp_q.push_back({e_out, 2'(m_sel), e_chg, e_rej, logic'(m_vend | m_refund), 4'(m_credit)});
  endtask

  task automatic step(input logic [1:0] c, input logic sv, input logic [1:0] s, input logic cn);
    @(negedge clk);
    coin = c; sel_valid = sv; sel = s; cancel = cn;
    model_and_push(c, sv, s, cn);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(2'b00, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic check_now(input string name, input logic [10:0] act, input logic [10:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s t=%0t got=%h expected=%h", name, $time, act, req);
    end
  endtask

  initial begin : monitor
    logic [10:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_now("cycle{out,out_sel,change,coin_rej,busy,credit}",
                  {out, out_sel, change, coin_rej, busy, credit}, e);
      end
    end
  end

  initial begin : stim
    #2 rst = 1'b1;
    #1 check_now("reset_outputs", {out, out_sel, change, coin_rej, busy, credit}, 11'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Rs.5 + Rs.10, buy product 0.
    step(COIN_5, 0, 0, 0); step(COIN_10, 0, 0, 0); step(COIN_NONE, 1, 2'd0, 0); idle(3);
    // Rs.20, buy product 1, one Rs.10 change.
    step(COIN_20, 0, 0, 0); step(COIN_NONE, 1, 2'd1, 0); idle(4);
    // Insufficient credit for product 3, then cancel.
    step(COIN_5, 0, 0, 0); step(COIN_NONE, 1, 2'd3, 0); step(COIN_NONE, 0, 0, 1); idle(3);
    // Fill to the ceiling, overflow coin rejected, refund 6 x Rs.10.
    step(COIN_20, 0, 0, 0); step(COIN_20, 0, 0, 0); step(COIN_20, 0, 0, 0);
    step(COIN_5, 0, 0, 0); step(COIN_NONE, 0, 0, 1); idle(8);
    // Select and coin in the same cycle; coin during refund.
    step(COIN_5, 0, 0, 0); step(COIN_10, 0, 0, 0); step(COIN_10, 1, 2'd0, 0); idle(2);
    step(COIN_20, 0, 0, 0); step(COIN_NONE, 0, 0, 1); step(COIN_10, 0, 0, 0); idle(3);

    // Reset in the middle of a refund.
    step(COIN_20, 0, 0, 0); step(COIN_5, 0, 0, 0); step(COIN_NONE, 0, 0, 1); idle(2);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_now("reset_mid_refund", {out, change, coin_rej, busy, credit}, 9'd0);
    @(negedge clk);
    rst = 1'b0;
    m_credit = 0; m_vend = 0; m_refund = 0; m_sel = 0;
    idle(4);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      logic [1:0] c;
      c = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
      step(c, ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
           ($urandom_range(0, 15) == 0));
    end
    idle(10);
    @(negedge clk);
    @(negedge clk);
    check_now("scoreboard_drained", 11'(exp_q.size()), 11'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog t=%0t got=timeout expected=finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/vend_multi_fsm.md
Name: vend_multi_fsm

Overview:
- Parametrised successor to the single-product Rs.15 vending controller.
- Accepts Rs.5/Rs.10/Rs.20 coins into a saturating credit register and serves NUM_PROD products with per-product prices.
- Dispenses on a select request and returns change as a serial coin stream, largest coin first.
- Sits between the coin-acceptor front end and the dispenser/coin-hopper drivers.

Parameters:
- NUM_PROD, 4, number of selectable products; SEL_W = max(1,$clog2(NUM_PROD)).
- PRICE_W, 4, width of one price entry, in credit units (1 unit = Rs.5).
- PRICES, 16'h6423, packed price table; product i price = PRICES[i*PRICE_W +: PRICE_W]. Default prices: p0=3 (Rs.15), p1=2, p2=4, p3=6.
- MAX_CREDIT, 12, credit ceiling in units (Rs.60); CREDIT_W = $clog2(MAX_CREDIT+1).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in  in  2  coin this cycle: 00 none, 01 Rs.5 (1 unit), 10 Rs.10 (2 units), 11 Rs.20 (4 units).
- sel_valid  in  1  product select request.
- sel  in  SEL_W  product index; qualified by sel_valid.
- cancel  in  1  refund request.
- out  out  1  dispense pulse, one cycle.
- out_sel  out  SEL_W  product being dispensed; valid while out=1, otherwise holds its last value.
- change  out  2  change coin this cycle: 00 none, 01 Rs.5, 10 Rs.10.
- coin_rej  out  1  one-cycle pulse: the coin presented in the previous cycle was not credited.
- busy  out  1  high in VEND and REFUND.
- credit  out  CREDIT_W  current credit in units.

Behaviour:
- All outputs are registered.
- Reset (async, immediate): state=IDLE, credit=0, out=0, out_sel=0, change=00, coin_rej=0, busy=0. Reset during VEND or REFUND discards the remaining credit; no change is emitted.
- States: IDLE (credit==0), COLLECT (credit>0), VEND, REFUND.
- IDLE/COLLECT input priority per cycle: cancel > sel_valid > coin. Any coin that loses to a higher-priority event in the same cycle is rejected (coin_rej=1 next cycle).
- Coin handling:
  - If credit+value <= MAX_CREDIT: credit += value, state -> COLLECT.
  - Otherwise: credit unchanged, coin_rej=1 next cycle.
- Select handling:
  - Out-of-range index (sel >= NUM_PROD): ignored, as if sel_valid=0.
  - Sufficient credit (credit >= price[sel]): credit -= price at the edge, out_sel <= sel, state -> VEND.
  - Insufficient credit: request ignored, credit retained, no pulse.
- Cancel: credit>0 -> REFUND; credit==0 -> no effect.
- VEND: lasts exactly one cycle with out=1, busy=1.
  - Latency: sel accepted at edge N, out high between edges N and N+1.
  - Exit: credit>0 -> REFUND, else -> IDLE.
- REFUND: one coin per cycle on change.
  - credit>=2: change=10, credit-=2.
  - credit==1: change=01, credit-=1.
  - After the last coin -> IDLE; change=00 the following cycle.
- In VEND and REFUND: sel_valid and cancel are ignored; any coin is rejected (coin_rej pulse).
- Arithmetic:
  - Credit never exceeds MAX_CREDIT or underflows.
  - Add and subtract use CREDIT_W+1 bits internally.
  - Elaboration check: every price <= MAX_CREDIT and every price > 0.

Decomposition:
- Package vend_pkg holds:
  - coin encodings COIN_NONE/COIN_5/COIN_10/COIN_20;
  - change encodings;
  - state enum vend_state_t;
  - function coin_units(in) -> units.
- One sub-module, vend_change_gen: given credit, produces the next change coin and the decremented credit (combinational, used in REFUND).

Test Plan:
- Rs.5 then Rs.10, then sel=0 -> out=1 for one cycle, out_sel=0, credit 3->0, change stays 00, busy low next cycle, state IDLE.
- Rs.20, then sel=1 -> out pulse with out_sel=1, then one cycle change=10, credit 0, busy deasserts.
- Rs.5, then sel=3 (price 6) -> no out, credit stays 1; then cancel -> change=01 for one cycle, credit 0.
- Three Rs.20 (credit 12), then Rs.5 -> coin_rej=1 one cycle, credit stays 12; then cancel -> six consecutive cycles of change=10.
- Credit 3, same cycle sel_valid=1 (sel=0) and in=10 -> out pulse, coin_rej=1, credit 0. Rs.10 inserted during REFUND -> coin_rej=1, refund sequence unchanged.
- Credit 5 mid-REFUND, assert rst between clock edges -> change=00, credit=0, busy=0 immediately; after release, state IDLE with no further change coins.
